extra1_sched: RTL

Round-robin scheduler that shares one pipelined ((A+B)*4)+C compute unit among NREQ requesters. Accepts one operand triple per cycle from the granted requester, tags it with the requester index, runs it through a 3-stage pipeline, and returns the 36-bit result with its tag over a valid/ready output port. It sits between the operand sources and the result consumer, replacing per-source copies of the arithmetic datapath.

---
 rtl/extra1_sched_if.sv | 38 +++
 rtl/extra1_sched.sv | 122 ++++++++++++
 2 files changed

// File: rtl/extra1_sched_if.sv
// ---------------------------------------------------------------------------
// extra1_sched_if
// Handshake bundle between the requesters, the shared compute scheduler and
// the result consumer.
//   req_valid [NREQ]      : per-requester operand valid  (requester -> sched)
//   req_ready [NREQ]      : per-requester accept, one-hot or zero
//   req_a/b/c [32*NREQ]   : operands, requester i at [32i+31:32i]
//   res_valid / res_ready : result handshake              (sched <-> consumer)
//   res_q [36]            : ((A+B)*4)+C
//   res_id [IDW]          : requester index that issued the result
//   in_flight [2]         : number of occupied pipeline stages
// Modports: slave = scheduler side, master = requester/consumer side.
// ---------------------------------------------------------------------------
interface extra1_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [32*NREQ-1:0] req_c;
  logic               res_valid;
  logic               res_ready;
  logic [35:0]        res_q;
  logic [IDW-1:0]     res_id;
  logic [1:0]         in_flight;

  modport slave (
    input  req_valid, req_a, req_b, req_c, res_ready,
    output req_ready, res_valid, res_q, res_id, in_flight
  );

  modport master (
    output req_valid, req_a, req_b, req_c, res_ready,
    input  req_ready, res_valid, res_q, res_id, in_flight
  );
endinterface

// File: rtl/extra1_sched.sv
// ---------------------------------------------------------------------------
// extra1_sched
// Round-robin scheduler sharing one 3-stage ((A+B)*4)+C pipeline among NREQ
// requesters. Results return in acceptance order tagged with the requester
// index.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : extra1_sched_if.slave (request, result and status signals)
// Build option:
//   EXTRA1_SCHED_FIXED_PRIO_EN - when defined, the pointer is frozen at 0 so
//   the arbiter becomes fixed priority (lowest index wins).
// ---------------------------------------------------------------------------
module extra1_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  extra1_sched_if.slave  bus
);

  logic             w_advance;
  logic             w_found;
  logic             w_accept;
  logic [IDW-1:0]   w_grant;
  logic [31:0]      w_a [NREQ];
  logic [31:0]      w_b [NREQ];
  logic [31:0]      w_c [NREQ];

  logic [IDW-1:0]   r_ptr;
  logic             r_v1, r_v2, r_v3;
  logic [31:0]      r_a1, r_b1, r_c1;
  logic [IDW-1:0]   r_id1;
  logic [32:0]      r_sum2;
  logic [31:0]      r_c2;
  logic [IDW-1:0]   r_id2;
  logic [35:0]      r_q3;
  logic [IDW-1:0]   r_id3;

  // Whole pipeline moves together; it only stalls when a result is stuck.
  assign w_advance = !r_v3 || bus.res_ready;

  // Unpack operand buses and build the one-hot ready vector.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign w_a[gi] = bus.req_a[32*gi +: 32];
      assign w_b[gi] = bus.req_b[32*gi +: 32];
      assign w_c[gi] = bus.req_c[32*gi +: 32];
      assign bus.req_ready[gi] = w_accept && (w_grant == IDW'(gi));
    end
  endgenerate

  // Rotating search starting at r_ptr; first valid requester wins.
  always_comb begin
    logic [IDW:0] w_idx;
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NREQ)) begin
        w_idx = w_idx - (IDW+1)'(NREQ);
      end
      if (!w_found && bus.req_valid[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_idx[IDW-1:0];
      end
    end
  end

  // Reset gates the accept so no requester sees ready while the block is held.
  assign w_accept = w_found && w_advance && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_a1   <= '0;
      r_b1   <= '0;
      r_c1   <= '0;
      r_id1  <= '0;
      r_sum2 <= '0;
      r_c2   <= '0;
      r_id2  <= '0;
      r_q3   <= '0;
      r_id3  <= '0;
    end else if (w_advance) begin
`ifndef EXTRA1_SCHED_FIXED_PRIO_EN
      if (w_accept) begin
        r_ptr <= (w_grant == IDW'(NREQ-1)) ? '0 : w_grant + IDW'(1);
      end
`endif
      // Stage 1: capture operands of the granted requester.
      r_v1 <= w_accept;
      if (w_accept) begin
        r_a1  <= w_a[w_grant];
        r_b1  <= w_b[w_grant];
        r_c1  <= w_c[w_grant];
        r_id1 <= w_grant;
      end
      // Stage 2: 33-bit sum keeps the carry.
      r_v2   <= r_v1;
      r_sum2 <= {1'b0, r_a1} + {1'b0, r_b1};
      r_c2   <= r_c1;
      r_id2  <= r_id1;
      // Stage 3: shift by two and add C; 36 bits cannot overflow.
      r_v3  <= r_v2;
      r_q3  <= {1'b0, r_sum2, 2'b00} + {4'b0000, r_c2};
      r_id3 <= r_id2;
    end
  end

  assign bus.res_valid = r_v3;
  assign bus.res_q     = r_q3;
  assign bus.res_id    = r_id3;
  assign bus.in_flight = {1'b0, r_v1} + {1'b0, r_v2} + {1'b0, r_v3};

endmodule
